// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_pkg
//  Purpose  : Shared encodings for the execute stage: ALU control codes,
//             multiply/divide op select, mul/div FSM states, link register.
//  Revision : 1.0 - initial release
// ============================================================================
package ex_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_MFHI = 4'b1010;
    localparam logic [3:0] ALU_MFLO = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    localparam logic MD_MULTU = 1'b0;
    localparam logic MD_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [4:0] REG_RA = 5'd31;

endpackage : ex_pkg
`default_nettype wire

// File: rtl/ex_stage_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative unsigned multiply (shift-add) / divide (restoring),
//             one bit per cycle, with architectural HI/LO registers.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import ex_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MD_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              stall_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(MD_STEPS + 1);

    // One working register serves both ops: upper half is the partial
    // product / remainder, lower half the multiplier / quotient-in-progress.
    md_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_q, op_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [2*DATA_W-1:0] work_q, work_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W-1:0]   div_diff;
    logic [2*DATA_W-1:0] step_next;

    // Single iteration of the selected algorithm on the working register.
    always_comb begin
        mul_sum   = {1'b0, work_q[2*DATA_W-1:DATA_W]} +
                    (work_q[0] ? {1'b0, b_q} : {(DATA_W+1){1'b0}});
        div_shift = {work_q[2*DATA_W-1:DATA_W], work_q[DATA_W-1]};
        div_diff  = div_shift[DATA_W-1:0] - b_q;
        if (op_q == MD_DIVU) begin
            if (div_shift >= {1'b0, b_q})
                step_next = {div_diff, work_q[DATA_W-2:0], 1'b1};
            else
                step_next = {div_shift[DATA_W-1:0], work_q[DATA_W-2:0], 1'b0};
        end else begin
            step_next = {mul_sum, work_q[DATA_W-1:1]};
        end
    end

    // Next-state and datapath update for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        b_d     = b_q;
        work_d  = work_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    op_d    = op_i;
                    b_d     = b_i;
                    work_d  = {{DATA_W{1'b0}}, a_i};
                    cnt_d   = '0;
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                work_d = step_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MD_STEPS - 1)) begin
                    hi_d    = step_next[2*DATA_W-1:DATA_W];
                    lo_d    = step_next[DATA_W-1:0];
                    state_d = MD_DONE;
                end
            end
            // Instruction is still in EX this cycle; start is ignored.
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // State register; reset aborts any operation and clears HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            b_q     <= '0;
            work_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            b_q     <= b_d;
            work_q  <= work_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o  = (state_q != MD_IDLE);
    assign stall_o = ((state_q == MD_IDLE) && start_i) || (state_q == MD_BUSY);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule : muldiv_unit
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage
//  Purpose  : Execute stage: operand forwarding, ALU, destination select,
//             JAL link path and the iterative multiply/divide unit.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MD_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rd1_i,
    input  logic [DATA_W-1:0] rd2_i,
    input  logic [DATA_W-1:0] immed_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic              alu_src_i,
    input  logic              reg_dst_i,
    input  logic [3:0]        alu_ctrl_i,
    input  logic              jal_i,
    input  logic [DATA_W-1:0] link_i,
    input  logic              md_start_i,
    input  logic              md_op_i,
    input  logic              mem_regwr_i,
    input  logic [4:0]        mem_rd_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              wb_regwr_i,
    input  logic [4:0]        wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [4:0]        dst_reg_o,
    output logic              stall_o,
    output logic              md_busy_o
);

    logic [DATA_W-1:0] op_a, fwd_b, op_b, alu_res, hi, lo;
    logic [4:0]        shamt;
    logic              md_stall;

    // Operand forwarding: the younger EX/MEM result wins over MEM/WB; r0 never.
    always_comb begin
        if (mem_regwr_i && (mem_rd_i != 5'd0) && (mem_rd_i == rs_i))
            op_a = mem_data_i;
        else if (wb_regwr_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs_i))
            op_a = wb_data_i;
        else
            op_a = rd1_i;

        if (mem_regwr_i && (mem_rd_i != 5'd0) && (mem_rd_i == rt_i))
            fwd_b = mem_data_i;
        else if (wb_regwr_i && (wb_rd_i != 5'd0) && (wb_rd_i == rt_i))
            fwd_b = wb_data_i;
        else
            fwd_b = rd2_i;
    end

    assign op_b  = alu_src_i ? immed_i : fwd_b;
    assign shamt = immed_i[10:6];

    // ALU: wrap-around arithmetic, unknown codes produce zero.
    always_comb begin
        case (alu_ctrl_i)
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_NOR:  alu_res = ~(op_a | op_b);
            ALU_SLL:  alu_res = op_b << shamt;
            ALU_SRL:  alu_res = op_b >> shamt;
            ALU_MFHI: alu_res = hi;
            ALU_MFLO: alu_res = lo;
            default:  alu_res = '0;
        endcase
    end

    // Result and destination select; JAL overrides both.
    always_comb begin
        if (jal_i) begin
            alu_result_o = link_i;
            dst_reg_o    = REG_RA;
        end else begin
            alu_result_o = alu_res;
            dst_reg_o    = reg_dst_i ? rd_i : rt_i;
        end
    end

    assign store_data_o = fwd_b;

    muldiv_unit #(
        .DATA_W   (DATA_W),
        .MD_STEPS (MD_STEPS)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (md_start_i),
        .op_i    (md_op_i),
        .a_i     (op_a),
        .b_i     (fwd_b),
        .busy_o  (md_busy_o),
        .stall_o (md_stall),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    // HI/LO reads must wait until the unit has fully returned to IDLE.
    assign stall_o = md_stall ||
                     (md_busy_o && ((alu_ctrl_i == ALU_MFHI) || (alu_ctrl_i == ALU_MFLO)));

endmodule : ex_stage
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_stage
//  Purpose  : Self-checking bench for ex_stage: directed cases plus random
//             forwarding/ALU and mul/div traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd1_i, rd2_i, immed_i, link_i, mem_data_i, wb_data_i;
    logic [4:0]  rs_i, rt_i, rd_i, mem_rd_i, wb_rd_i;
    logic        alu_src_i, reg_dst_i, jal_i, md_start_i, md_op_i;
    logic        mem_regwr_i, wb_regwr_i;
    logic [3:0]  alu_ctrl_i;
    logic [31:0] alu_result_o, store_data_o;
    logic [4:0]  dst_reg_o;
    logic        stall_o, md_busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Model architectural state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .rd1_i        (rd1_i),
        .rd2_i        (rd2_i),
        .immed_i      (immed_i),
        .rs_i         (rs_i),
        .rt_i         (rt_i),
        .rd_i         (rd_i),
        .alu_src_i    (alu_src_i),
        .reg_dst_i    (reg_dst_i),
        .alu_ctrl_i   (alu_ctrl_i),
        .jal_i        (jal_i),
        .link_i       (link_i),
        .md_start_i   (md_start_i),
        .md_op_i      (md_op_i),
        .mem_regwr_i  (mem_regwr_i),
        .mem_rd_i     (mem_rd_i),
        .mem_data_i   (mem_data_i),
        .wb_regwr_i   (wb_regwr_i),
        .wb_rd_i      (wb_rd_i),
        .wb_data_i    (wb_data_i),
        .alu_result_o (alu_result_o),
        .store_data_o (store_data_o),
        .dst_reg_o    (dst_reg_o),
        .stall_o      (stall_o),
        .md_busy_o    (md_busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [4:0] spec, input logic [31:0] rf);
        if (mem_regwr_i && mem_rd_i != 0 && mem_rd_i == spec) return mem_data_i;
        if (wb_regwr_i && wb_rd_i != 0 && wb_rd_i == spec)    return wb_data_i;
        return rf;
    endfunction

    function automatic logic [31:0] m_result();
        logic [31:0] a, b;
        int sh;
        if (jal_i) return link_i;
        a  = m_fwd(rs_i, rd1_i);
        b  = alu_src_i ? immed_i : m_fwd(rt_i, rd2_i);
        sh = int'((immed_i >> 6) & 32'h1f);
        case (alu_ctrl_i)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd6:  return a - b;
            4'd7:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd12: return ~(a | b);
            4'd8:  return b << sh;
            4'd9:  return b >> sh;
            4'd10: return m_hi;
            4'd11: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd1_i = 0; rd2_i = 0; immed_i = 0; link_i = 0;
        rs_i = 0; rt_i = 0; rd_i = 0;
        alu_src_i = 0; reg_dst_i = 0; jal_i = 0;
        alu_ctrl_i = 4'd2; md_start_i = 0; md_op_i = 0;
        mem_regwr_i = 0; mem_rd_i = 0; mem_data_i = 0;
        wb_regwr_i = 0; wb_rd_i = 0; wb_data_i = 0;
    endtask

    task automatic check_hilo(input string tag);
        alu_ctrl_i = 4'd10;
        #1;
        check({tag, "_hi"}, alu_result_o, m_hi);
        alu_ctrl_i = 4'd11;
        #1;
        check({tag, "_lo"}, alu_result_o, m_lo);
        alu_ctrl_i = 4'd2;
        #1;
    endtask

    // Run one MULTU/DIVU from start to IDLE and check stall length and HI/LO.
    task automatic md_run(input logic op, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        logic [63:0] prod;
        idle_inputs();
        rs_i = 5'd1; rt_i = 5'd2; rd1_i = a; rd2_i = b;
        md_op_i = op; md_start_i = 1'b1;
        #1;
        cyc = (stall_o === 1'b1) ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (stall_o !== 1'b1) break;
            cyc++;
        end
        check("md_stall_len", 32'(cyc), 32'd33);
        check("md_done_busy", {31'd0, md_busy_o}, 32'd1);
        alu_ctrl_i = 4'd11;
        #1;
        check("md_mflo_in_done_stall", {31'd0, stall_o}, 32'd1);
        alu_ctrl_i = 4'd2;
        #1;
        step();
        md_start_i = 1'b0;
        #1;
        check("md_idle_busy", {31'd0, md_busy_o}, 32'd0);
        if (op) begin
            if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
            else begin m_lo = a / b; m_hi = a % b; end
        end else begin
            prod = 64'(a) * 64'(b);
            m_hi = prod[63:32];
            m_lo = prod[31:0];
        end
        check_hilo(op ? "divu" : "multu");
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_busy",  {31'd0, md_busy_o}, 32'd0);
        check_hilo("rst");

        // Forwarding priority and r0
        rs_i = 5; rt_i = 5; rd1_i = 32'h100; rd2_i = 32'h200;
        mem_regwr_i = 1; mem_rd_i = 5; mem_data_i = 32'h11;
        wb_regwr_i = 1;  wb_rd_i = 5;  wb_data_i = 32'h22;
        #1; check("fwd_mem", alu_result_o, 32'h22);
        mem_regwr_i = 0;
        #1; check("fwd_wb", alu_result_o, 32'h44);
        rs_i = 0; mem_regwr_i = 1; mem_rd_i = 0; wb_rd_i = 0;
        #1; check("fwd_r0", alu_result_o, 32'h300);

        // ALU directed
        idle_inputs();
        rs_i = 1; rt_i = 2; rd1_i = 5; rd2_i = 32'hFFFF_FFFF;
        alu_ctrl_i = 4'd2; #1; check("alu_add", alu_result_o, 32'd4);
        alu_ctrl_i = 4'd6; #1; check("alu_sub", alu_result_o, 32'd6);
        alu_ctrl_i = 4'd7; #1; check("alu_slt", alu_result_o, 32'd0);
        rd2_i = 32'd1; immed_i = 32'h7C0; alu_ctrl_i = 4'd8;
        #1; check("alu_sll31", alu_result_o, 32'h8000_0000);

        // JAL
        idle_inputs();
        jal_i = 1; link_i = 32'h408; reg_dst_i = 1; rd_i = 7; rt_i = 3;
        #1;
        check("jal_res", alu_result_o, 32'h408);
        check("jal_dst", {27'd0, dst_reg_o}, 32'd31);

        // Directed mul/div
        step();
        md_run(1'b0, 32'hFFFF_FFFF, 32'd2);
        md_run(1'b1, 32'd100, 32'd7);
        md_run(1'b1, 32'd9, 32'd0);

        // Reset in the middle of a busy operation
        idle_inputs();
        rs_i = 1; rt_i = 2; rd1_i = 32'h1234; rd2_i = 32'h77; md_start_i = 1;
        for (int i = 0; i < 11; i++) step();
        check("mid_busy", {31'd0, md_busy_o}, 32'd1);
        rst = 1; md_start_i = 0;
        step();
        rst = 0;
        #1;
        m_hi = 0; m_lo = 0;
        check("abort_stall", {31'd0, stall_o}, 32'd0);
        check("abort_busy",  {31'd0, md_busy_o}, 32'd0);
        check_hilo("abort");

        // Random forwarding / ALU / destination traffic
        for (int i = 0; i < 200; i++) begin
            rd1_i = $urandom; rd2_i = $urandom; immed_i = $urandom;
            mem_data_i = $urandom; wb_data_i = $urandom; link_i = $urandom;
            rs_i = 5'($urandom_range(0, 3)); rt_i = 5'($urandom_range(0, 3));
            rd_i = 5'($urandom);
            mem_rd_i = 5'($urandom_range(0, 3)); wb_rd_i = 5'($urandom_range(0, 3));
            mem_regwr_i = 1'($urandom); wb_regwr_i = 1'($urandom);
            alu_src_i = 1'($urandom); reg_dst_i = 1'($urandom);
            jal_i = ($urandom_range(0, 7) == 0);
            alu_ctrl_i = 4'($urandom);
            md_start_i = 0;
            #1;
            check("rnd_res",   alu_result_o, m_result());
            check("rnd_store", store_data_o, m_fwd(rt_i, rd2_i));
            check("rnd_dst",   {27'd0, dst_reg_o},
                  jal_i ? 32'd31 : (reg_dst_i ? {27'd0, rd_i} : {27'd0, rt_i}));
            check("rnd_stall", {31'd0, stall_o}, 32'd0);
        end

        // Random mul/div
        step();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            md_run(1'($urandom), ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_ex_stage
`default_nettype wire
